// File: rtl/fprnd_sched.sv
// Round-robin share of one FPU rounder among NREQ units: issue reg A feeds rounder, reg B holds result; 2-cycle latency.
// B full with out_ready low stalls A and drops req_ready; `FPRND_SCHED_TRAP_EN adds flag-triggered grant stall.
module fprnd_sched #(
    parameter int NREQ  = 2,
    parameter int TAG_W = 4,
    localparam int SRC_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*126-1:0]    req_data,
    input  logic [NREQ*TAG_W-1:0]  req_tag,
    input  logic                   ovf_en,
    input  logic                   unf_en,
    output logic [125:0]           rnd_bundle,
    output logic                   rnd_ovfen,
    output logic                   rnd_unfen,
    input  logic [63:0]            rnd_fp,
    input  logic [4:0]             rnd_ieee,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [63:0]            out_fp,
    output logic [4:0]             out_ieee,
    output logic [SRC_W-1:0]       out_src,
    output logic [TAG_W-1:0]       out_tag,
    input  logic                   flag_clr,
    output logic [4:0]             sticky_flags
`ifdef FPRND_SCHED_TRAP_EN
    ,
    input  logic [4:0]             trap_mask,
    output logic                   trap,
    input  logic                   trap_ack
`endif
);

    localparam int BW = 126;

    logic             a_vld_q, b_vld_q;
    logic [BW-1:0]    a_bundle_q;
    logic [TAG_W-1:0] a_tag_q, b_tag_q;
    logic [SRC_W-1:0] a_src_q, b_src_q, ptr_q, ptr_d;
    logic             a_ovfen_q, a_unfen_q;
    logic [63:0]      b_fp_q;
    logic [4:0]       b_ieee_q, sticky_q;
    logic             b_adv, a_free, grant_ok, gnt_any, accept;
    logic [SRC_W-1:0] gnt_idx;

    // Index k positions above base, wrapping at NREQ.
    function automatic logic [SRC_W-1:0] rr_idx(input logic [SRC_W-1:0] base, input int k);
        int j;
        j = int'(base) + k;
        if (j >= NREQ) j = j - NREQ;
        return SRC_W'(j);
    endfunction

    assign b_adv  = a_vld_q & (~b_vld_q | out_ready);
    assign a_free = ~a_vld_q | b_adv;

`ifdef FPRND_SCHED_TRAP_EN
    logic trap_q;
    assign grant_ok = a_free & ~trap_q;
    assign trap     = trap_q;

    // A new trap event wins over a same-cycle acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= (trap_q & ~trap_ack) | (b_adv & |(rnd_ieee & trap_mask));
        end
    end
`else
    assign grant_ok = a_free;
`endif

    // Descending scan so the requester closest to the pointer wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[rr_idx(ptr_q, k)]) begin
                gnt_any = 1'b1;
                gnt_idx = rr_idx(ptr_q, k);
            end
        end
    end

    assign accept = gnt_any & grant_ok;
    assign ptr_d  = rr_idx(gnt_idx, 1);

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_vld_q    <= 1'b0;
            a_bundle_q <= '0;
            a_tag_q    <= '0;
            a_src_q    <= '0;
            a_ovfen_q  <= 1'b0;
            a_unfen_q  <= 1'b0;
            ptr_q      <= '0;
            b_vld_q    <= 1'b0;
            b_fp_q     <= '0;
            b_ieee_q   <= '0;
            b_src_q    <= '0;
            b_tag_q    <= '0;
            sticky_q   <= '0;
        end else begin
            if (accept) begin
                a_vld_q    <= 1'b1;
                a_bundle_q <= req_data[int'(gnt_idx)*BW +: BW];
                a_tag_q    <= req_tag[int'(gnt_idx)*TAG_W +: TAG_W];
                a_src_q    <= gnt_idx;
                a_ovfen_q  <= ovf_en;
                a_unfen_q  <= unf_en;
                ptr_q      <= ptr_d;
            end else if (b_adv) begin
                a_vld_q    <= 1'b0;
            end

            if (b_adv) begin
                b_vld_q  <= 1'b1;
                b_fp_q   <= rnd_fp;
                b_ieee_q <= rnd_ieee;
                b_src_q  <= a_src_q;
                b_tag_q  <= a_tag_q;
            end else if (out_ready) begin
                b_vld_q  <= 1'b0;
            end

            // Clear applies before the OR of a same-cycle capture.
            if (b_adv) begin
                sticky_q <= (flag_clr ? 5'b0 : sticky_q) | rnd_ieee;
            end else if (flag_clr) begin
                sticky_q <= '0;
            end
        end
    end

    assign rnd_bundle   = a_bundle_q;
    assign rnd_ovfen    = a_ovfen_q;
    assign rnd_unfen    = a_unfen_q;
    assign out_valid    = b_vld_q;
    assign out_fp       = b_fp_q;
    assign out_ieee     = b_ieee_q;
    assign out_src      = b_src_q;
    assign out_tag      = b_tag_q;
    assign sticky_flags = sticky_q;

endmodule
